mha_head_sched: RTL

Sequencer that runs the H_NUM heads of a multi-head attention layer, one after another, through a single shared attention engine. The controller is triggered once. For each head it then:
- selects the head's Q/K/V slice,
- pulses the engine start,
- waits for the engine valid,
- hands the result to the output buffer under a ready handshake.

It sits between the layer-level control and the attention datapath. It also provides a watchdog timeout, an abort, and a run-length cycle counter.

---
 rtl/mha_head_sched.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mha_head_sched.sv
// mha_head_sched: runs H_NUM attention heads one after another through a single
// shared engine, with a watchdog timeout, an abort, and a run-length cycle counter.
module mha_head_sched #(
    parameter int H_NUM   = 8,
    parameter int TIMEOUT = 4096,
    parameter int HW      = (H_NUM > 1) ? $clog2(H_NUM) : 1,
    parameter int TW      = $clog2(TIMEOUT)
) (
    input  logic          I_CLK,
    input  logic          I_RST_N,
    input  logic          I_START,
    input  logic          I_ABORT,
    input  logic          I_ATT_VLD,
    input  logic          I_WR_RDY,
    output logic [HW-1:0] O_HEAD_IDX,
    output logic          O_ATT_START,
    output logic          O_WR_EN,
    output logic [HW-1:0] O_WR_HEAD,
    output logic          O_BUSY,
    output logic          O_DONE,
    output logic          O_ERR,
    output logic [31:0]   O_CYC_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_GO,
        S_WAIT,
        S_WR,
        S_FIN,
        S_ERR
    } state_t;

    state_t        r_state;
    state_t        w_nxt;
    logic [HW-1:0] r_head;
    logic [HW-1:0] w_head_nxt;
    logic [TW-1:0] r_tmr;
    logic [TW-1:0] w_tmr_nxt;
    logic          r_vld_d;
    logic          r_err;
    logic          w_err_nxt;
    logic [31:0]   r_cyc;
    logic [31:0]   w_cyc_nxt;
    logic          w_acc;
    logic          w_tmo;
    logic          w_last;

    assign w_acc  = I_ATT_VLD & ~r_vld_d;
    assign w_tmo  = (r_tmr == TW'(TIMEOUT - 1));
    assign w_last = (r_head == HW'(H_NUM - 1));

    always_comb begin
        w_nxt      = r_state;
        w_head_nxt = r_head;
        w_tmr_nxt  = r_tmr;
        w_err_nxt  = r_err;
        w_cyc_nxt  = r_cyc;
        unique case (r_state)
            S_IDLE: begin
                if (I_START) begin
                    w_nxt      = S_SEL;
                    w_head_nxt = '0;
                    w_err_nxt  = 1'b0;
                    // trigger cycle plus the SEL cycle being entered
                    w_cyc_nxt  = 32'd2;
                end
            end
            S_SEL: w_nxt = S_GO;
            S_GO: begin
                w_nxt     = S_WAIT;
                w_tmr_nxt = '0;
            end
            S_WAIT: begin
                if (w_acc) begin
                    w_nxt = S_WR;
                end else if (w_tmo) begin
                    w_nxt     = S_ERR;
                    w_err_nxt = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            S_WR: begin
                if (I_WR_RDY) begin
                    if (w_last) begin
                        w_nxt = S_FIN;
                    end else begin
                        w_nxt      = S_SEL;
                        w_head_nxt = r_head + 1'b1;
                    end
                end
            end
            S_FIN, S_ERR: begin
                w_nxt      = S_IDLE;
                w_head_nxt = '0;
            end
            default: begin
                w_nxt      = S_IDLE;
                w_head_nxt = '0;
            end
        endcase
        if (r_state != S_IDLE && w_nxt != S_IDLE && r_cyc != '1) begin
            w_cyc_nxt = r_cyc + 32'd1;
        end
        // abort overrides everything, including a start request in IDLE
        if (I_ABORT) begin
            w_nxt      = S_IDLE;
            w_head_nxt = '0;
            w_tmr_nxt  = r_tmr;
            w_err_nxt  = r_err;
            w_cyc_nxt  = r_cyc;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_state <= S_IDLE;
            r_head  <= '0;
            r_tmr   <= '0;
            r_vld_d <= 1'b0;
            r_err   <= 1'b0;
            r_cyc   <= '0;
        end else begin
            r_state <= w_nxt;
            r_head  <= w_head_nxt;
            r_tmr   <= w_tmr_nxt;
            r_vld_d <= I_ATT_VLD;
            r_err   <= w_err_nxt;
            r_cyc   <= w_cyc_nxt;
        end
    end

    assign O_HEAD_IDX  = r_head;
    assign O_ATT_START = (r_state == S_GO);
    assign O_WR_EN     = (r_state == S_WR);
    assign O_WR_HEAD   = r_head;
    assign O_BUSY      = (r_state != S_IDLE);
    assign O_DONE      = (r_state == S_FIN);
    assign O_ERR       = r_err;
    assign O_CYC_CNT   = r_cyc;

endmodule
